// File: rtl/common.sv
`default_nettype none
// ============================================================================
// Package     : common
// Description : Shared pipeline types and constants: memory-access size
//               encodings, bubble markers and the write-back FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package common;

  // Memory-access size; bit 2 set marks the zero-extending (unsigned) forms.
  typedef enum logic [2:0] {
    MA_SIZE_B  = 3'b000,
    MA_SIZE_H  = 3'b001,
    MA_SIZE_W  = 3'b010,
    MA_SIZE_BU = 3'b100,
    MA_SIZE_HU = 3'b101
  } ma_size_t;

  // Bubble markers injected by upstream stages.
  localparam logic [31:0] NOP_PC = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_IR = 32'h0000_0013;

  // Write-back stage FSM states.
  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : cpu_load_align
// Description : Combinational load-data aligner. Shifts the read word down to
//               the addressed byte lane, sign/zero-extends it to 32 bits and
//               flags accesses that are not naturally aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_load_align
  import common::*;
(
  input  logic [31:0] data,
  input  ma_size_t    size,
  input  logic [1:0]  alignment,
  output logic [31:0] result,
  output logic        misaligned
);

  logic [31:0] shifted;

  // Move the addressed byte lane to bit 0, then extend per access size.
  always_comb begin
    shifted = data >> {alignment, 3'b000};
    case (size)
      MA_SIZE_B:  result = {{24{shifted[7]}}, shifted[7:0]};
      MA_SIZE_BU: result = {24'h000000, shifted[7:0]};
      MA_SIZE_H:  result = {{16{shifted[15]}}, shifted[15:0]};
      MA_SIZE_HU: result = {16'h0000, shifted[15:0]};
      default:    result = shifted;
    endcase
  end

  // Halfwords need an even offset; words need offset zero.
  always_comb begin
    case (size)
      MA_SIZE_H, MA_SIZE_HU: misaligned = alignment[0];
      MA_SIZE_W:             misaligned = (alignment != 2'b00);
      default:               misaligned = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_wb.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb
// Description : Pipeline write-back stage. Aligns load data, drives the
//               register-file write port, stalls while a load waits for
//               memory (with timeout fault) and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_wb
  import common::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dmem_read_data_i,
  input  logic        dmem_read_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ir_i,
  input  logic        load_i,
  input  ma_size_t    ma_size_i,
  input  logic [1:0]  ma_alignment_i,
  input  logic [31:0] wb_data_i,
  input  logic        wb_valid_i,
  output logic        halt_o,
  output logic [4:0]  wb_addr_async_o,
  output logic [31:0] wb_data_async_o,
  output logic        wb_valid_async_o,
  output logic        empty_async_o,
  output logic        load_fault_o,
  output logic [63:0] instret_o
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t          state_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic [63:0]        instret_q;
  logic [31:0]        load_data;
  logic               misaligned;
  logic               present;
  logic               retire;
  logic               unused_ir;

  cpu_load_align u_align (
    .data       (dmem_read_data_i),
    .size       (ma_size_i),
    .alignment  (ma_alignment_i),
    .result     (load_data),
    .misaligned (misaligned)
  );

  assign present         = (pc_i != NOP_PC);
  assign empty_async_o   = !present;
  assign wb_addr_async_o = ir_i[11:7];
  assign unused_ir       = ^{ir_i[31:12], ir_i[6:0]};

  // Write-port, stall and fault decode; all outputs quiet while in reset.
  always_comb begin
    halt_o           = 1'b0;
    wb_valid_async_o = 1'b0;
    load_fault_o     = 1'b0;
    wb_data_async_o  = wb_data_i;
    if (rst_ni && present) begin
      if (!load_i) begin
        wb_valid_async_o = wb_valid_i;
      end else begin
        wb_data_async_o = load_data;
        if (misaligned) begin
          load_fault_o = 1'b1;
        end else if (dmem_read_valid_i) begin
          wb_valid_async_o = wb_valid_i;
        end else if (state_q == WB_WAIT && wait_cnt_q == '0) begin
          load_fault_o = 1'b1;
        end else begin
          halt_o = 1'b1;
        end
      end
    end
  end

  assign retire = present && !halt_o;

  // Load-wait FSM: a stall in IDLE arms the timeout, leaving the stall exits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WB_IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (halt_o) begin
            state_q    <= WB_WAIT;
            wait_cnt_q <= CNT_W'(LOAD_TIMEOUT);
          end
        end
        default: begin
          if (halt_o) begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end else begin
            state_q <= WB_IDLE;
          end
        end
      endcase
    end
  end

  // Retired-instruction counter, faulting loads included; wraps at 2^64.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;

endmodule
`default_nettype wire
